// File: rtl/scpu_pipe.sv
// scpu_pipe: 5-stage IF/ID/EX/MEM/WB 16-bit-instruction CPU core.
// Ports: clk, rst, imem write port in; pc, halted, wb_* observation out.
module scpu_pipe #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_we,
  input  logic [7:0]        imem_addr,
  input  logic [15:0]       imem_wdata,
  output logic [7:0]        pc,
  output logic              halted,
  output logic              wb_valid,
  output logic [1:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data
);

  localparam int PW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic        v;
    logic [15:0] ir;
  } if_id_t;

  typedef struct packed {
    logic              v;
    logic [3:0]        op;
    logic [1:0]        ra;
    logic [1:0]        rb;
    logic [7:0]        imm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } id_ex_t;

  typedef struct packed {
    logic              v;
    logic [3:0]        op;
    logic [1:0]        ra;
    logic [7:0]        imm;
    logic [DATA_W-1:0] res;
  } ex_mem_t;

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [3:0][DATA_W-1:0] rf;
  logic [PW-1:0] pc_q, pc_n;
  if_id_t  if_id, if_id_n;
  id_ex_t  id_ex, id_ex_n;
  ex_mem_t ex_mem, ex_mem_n;
  logic stop_q, halted_q;

  logic [3:0] id_op;
  logic [1:0] id_ra, id_rb;
  logic id_alu, use_ra, use_rb;
  logic ld_use, id_halt, flush;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] fa, fb, ex_res;
  logic mem_fwd, mem_wr, wb_wr;
  logic [DATA_W-1:0] mem_res;

  assign pc     = 8'(pc_q);
  assign halted = halted_q;

  // ID decode, hazard detection, write-through register read
  assign id_op  = if_id.ir[15:12];
  assign id_ra  = if_id.ir[11:10];
  assign id_rb  = if_id.ir[9:8];
  assign id_alu = id_op inside {[OP_ADD:OP_XOR]};
  assign use_ra = id_alu || id_op == OP_ST || id_op == OP_BEQZ;
  assign use_rb = id_alu;

  assign ld_use = if_id.v && id_ex.v && id_ex.op == OP_LD &&
                  ((use_ra && id_ex.ra == id_ra) ||
                   (use_rb && id_ex.ra == id_rb));
  assign id_halt = if_id.v && id_op == OP_HALT;

  assign rd_a = (wb_valid && wb_reg == id_ra) ? wb_data : rf[id_ra];
  assign rd_b = (wb_valid && wb_reg == id_rb) ? wb_data : rf[id_rb];

  // EX operand forwarding; a LD in EX/MEM is never a source
  assign mem_fwd = ex_mem.v && ex_mem.op inside {[OP_ADD:OP_LDI]};

  always_comb begin
    fa = id_ex.a;
    if (mem_fwd && ex_mem.ra == id_ex.ra)
      fa = ex_mem.res;
    else if (wb_valid && wb_reg == id_ex.ra)
      fa = wb_data;
  end

  always_comb begin
    fb = id_ex.b;
    if (mem_fwd && ex_mem.ra == id_ex.rb)
      fb = ex_mem.res;
    else if (wb_valid && wb_reg == id_ex.rb)
      fb = wb_data;
  end

  // ST carries its data in res
  always_comb begin
    ex_res = fa;
    case (id_ex.op)
      OP_ADD:  ex_res = fa + fb;
      OP_SUB:  ex_res = fa - fb;
      OP_AND:  ex_res = fa & fb;
      OP_OR:   ex_res = fa | fb;
      OP_XOR:  ex_res = fa ^ fb;
      OP_LDI:  ex_res = DATA_W'(id_ex.imm);
      default: ex_res = fa;
    endcase
  end

  assign flush = id_ex.v && id_ex.op == OP_BEQZ && fa == '0;

  // MEM
  assign mem_wr  = ex_mem.v && ex_mem.op inside {[OP_ADD:OP_LD]};
  assign wb_wr   = mem_wr && !halted_q;
  assign mem_res = (ex_mem.op == OP_LD) ?
                   dmem[ex_mem.imm[AW-1:0]] : ex_mem.res;

  // next-state: a taken branch beats stall and HALT
  always_comb begin
    pc_n = pc_q;
    if (flush)
      pc_n = id_ex.imm[PW-1:0];
    else if (!(ld_use || id_halt || stop_q || halted_q))
      pc_n = (pc_q == PW'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
  end

  always_comb begin
    if_id_n = if_id;
    if (flush)
      if_id_n.v = 1'b0;
    else if (!ld_use) begin
      if (id_halt || stop_q || halted_q)
        if_id_n.v = 1'b0;
      else begin
        if_id_n.v  = 1'b1;
        if_id_n.ir = imem[pc_q];
      end
    end
  end

  always_comb begin
    id_ex_n.v   = if_id.v && !flush && !ld_use;
    id_ex_n.op  = id_op;
    id_ex_n.ra  = id_ra;
    id_ex_n.rb  = id_rb;
    id_ex_n.imm = if_id.ir[7:0];
    id_ex_n.a   = rd_a;
    id_ex_n.b   = rd_b;
  end

  always_comb begin
    ex_mem_n.v   = id_ex.v;
    ex_mem_n.op  = id_ex.op;
    ex_mem_n.ra  = id_ex.ra;
    ex_mem_n.imm = id_ex.imm;
    ex_mem_n.res = ex_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      if_id    <= '0;
      id_ex    <= '0;
      ex_mem   <= '0;
      stop_q   <= 1'b0;
      halted_q <= 1'b0;
      wb_valid <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
      rf       <= '0;
    end else begin
      pc_q     <= pc_n;
      if_id    <= if_id_n;
      id_ex    <= id_ex_n;
      ex_mem   <= ex_mem_n;
      stop_q   <= stop_q | (id_halt & ~flush);
      halted_q <= halted_q |
                  (ex_mem.v && ex_mem.op == OP_HALT);
      wb_valid <= wb_wr;
      if (wb_wr) begin
        wb_reg  <= ex_mem.ra;
        wb_data <= mem_res;
      end
      if (wb_valid)
        rf[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_addr[PW-1:0]] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (ex_mem.v && ex_mem.op == OP_ST && !halted_q)
      dmem[ex_mem.imm[AW-1:0]] <= ex_mem.res;
  end

endmodule

// File: tb/tb_scpu_pipe.sv
// tb_scpu_pipe: self-checking bench for scpu_pipe (8-bit and 16-bit).
// Program table + write-back scoreboard keyed by cycle.
module tb_scpu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_addr = '0;
  logic [15:0] imem_wdata = '0;

  logic [7:0]  pc8, pc16;
  logic        h8, h16, v8, v16;
  logic [1:0]  r8, r16;
  logic [7:0]  d8;
  logic [15:0] d16;

  scpu_pipe #(.DATA_W(8)) u8 (
    .clk(clk), .rst(rst), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc(pc8), .halted(h8), .wb_valid(v8),
    .wb_reg(r8), .wb_data(d8)
  );

  scpu_pipe #(.DATA_W(16)) u16 (
    .clk(clk), .rst(rst), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc(pc16), .halted(h16), .wb_valid(v16),
    .wb_reg(r16), .wb_data(d16)
  );

  typedef struct {
    logic [1:0]  r;
    logic [15:0] d;
    int          c;
  } wb_t;

  typedef struct packed {
    logic [15:0][15:0] code;
    logic [7:0][1:0]   wr;
    logic [7:0][15:0]  wd;
    logic [7:0][7:0]   wc;
    logic [3:0]        nwb;
    logic [7:0]        hc;
    logic [7:0]        ck;
    logic [7:0]        cpc;
  } vec_t;

  wb_t  sb[$];
  vec_t tbl[6];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   sel16 = 1'b0;
  int   hcnt;
  logic [7:0] pc_log[64];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample(input int k);
    logic v, h;
    logic [1:0] r;
    logic [15:0] d;
    wb_t e;
    v = sel16 ? v16 : v8;
    h = sel16 ? h16 : h8;
    r = sel16 ? r16 : r8;
    d = sel16 ? d16 : {8'h00, d8};
    pc_log[k] = sel16 ? pc16 : pc8;
    if (v) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_extra: got r%0d=%0h at cycle %0d expected none",
                 r, d, k);
      end else begin
        e = sb.pop_front();
        check("wb_reg", 32'(r), 32'(e.r));
        check("wb_data", 32'(d), 32'(e.d));
        check("wb_cycle", k, e.c);
      end
    end
    if (h && hcnt == 0) hcnt = k;
  endtask

  task automatic load(input logic [15:0][15:0] code);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_addr  = 8'(i);
      imem_wdata = code[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic go(input int exp_h, input int ck,
                    input logic [7:0] cpc);
    hcnt = 0;
    rst = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      sample(k);
      if (hcnt != 0 && k >= hcnt + 3) break;
    end
    check("halt_cycle", hcnt, exp_h);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    if (ck > 0) check("pc_at_cycle", 32'(pc_log[ck]), 32'(cpc));
  endtask

  task automatic push_tbl(input int i);
    for (int j = 0; j < int'(tbl[i].nwb); j++)
      sb.push_back('{r: tbl[i].wr[j], d: tbl[i].wd[j],
                     c: int'(tbl[i].wc[j])});
  endtask

  task automatic run_tbl(input int i);
    load(tbl[i].code);
    push_tbl(i);
    go(int'(tbl[i].hc), int'(tbl[i].ck), tbl[i].cpc);
  endtask

  task automatic wbe(input int i, input int j, input logic [1:0] r,
                     input logic [15:0] d, input logic [7:0] c);
    tbl[i].wr[j] = r;
    tbl[i].wd[j] = d;
    tbl[i].wc[j] = c;
  endtask

  initial begin
    logic [15:0][15:0] z;
    for (int i = 0; i < 6; i++) begin
      tbl[i] = '0;
      tbl[i].code = {16{16'hF000}};
    end
    // LDI r1,5; LDI r2,3; ADD r1,r2; HALT
    tbl[0].code[0] = 16'h6405;
    tbl[0].code[1] = 16'h6803;
    tbl[0].code[2] = 16'h1600;
    wbe(0, 0, 1, 16'h05, 4);
    wbe(0, 1, 2, 16'h03, 5);
    wbe(0, 2, 1, 16'h08, 6);
    tbl[0].nwb = 3; tbl[0].hc = 7; tbl[0].ck = 5; tbl[0].cpc = 4;
    // LDI r1,1; ADD r1,r1 x3
    tbl[1].code[0] = 16'h6401;
    tbl[1].code[1] = 16'h1500;
    tbl[1].code[2] = 16'h1500;
    tbl[1].code[3] = 16'h1500;
    wbe(1, 0, 1, 16'h01, 4);
    wbe(1, 1, 1, 16'h02, 5);
    wbe(1, 2, 1, 16'h04, 6);
    wbe(1, 3, 1, 16'h08, 7);
    tbl[1].nwb = 4; tbl[1].hc = 8; tbl[1].ck = 6; tbl[1].cpc = 5;
    // SUB/AND/OR/XOR with wrap
    tbl[2].code[0] = 16'h640F;
    tbl[2].code[1] = 16'h683C;
    tbl[2].code[2] = 16'h2600;
    tbl[2].code[3] = 16'h3900;
    tbl[2].code[4] = 16'h4600;
    tbl[2].code[5] = 16'h5600;
    wbe(2, 0, 1, 16'h0F, 4);
    wbe(2, 1, 2, 16'h3C, 5);
    wbe(2, 2, 1, 16'hD3, 6);
    wbe(2, 3, 2, 16'h10, 7);
    wbe(2, 4, 1, 16'hD3, 8);
    wbe(2, 5, 1, 16'hC3, 9);
    tbl[2].nwb = 6; tbl[2].hc = 10; tbl[2].ck = 8; tbl[2].cpc = 7;
    // ST / LD / load-use ADD
    tbl[3].code[0] = 16'h642A;
    tbl[3].code[1] = 16'h8410;
    tbl[3].code[2] = 16'h7810;
    tbl[3].code[3] = 16'h1A00;
    wbe(3, 0, 1, 16'h2A, 4);
    wbe(3, 1, 2, 16'h2A, 6);
    wbe(3, 2, 2, 16'h54, 8);
    tbl[3].nwb = 3; tbl[3].hc = 9; tbl[3].ck = 5; tbl[3].cpc = 4;
    // taken BEQZ, shadow LDI r3 flushed
    tbl[4].code[0] = 16'h6000;
    tbl[4].code[1] = 16'h9008;
    tbl[4].code[2] = 16'h6CFF;
    tbl[4].code[3] = 16'h6CFF;
    tbl[4].code[8] = 16'h6877;
    wbe(4, 0, 0, 16'h00, 4);
    wbe(4, 1, 2, 16'h77, 8);
    tbl[4].nwb = 2; tbl[4].hc = 9; tbl[4].ck = 4; tbl[4].cpc = 8;
    // not-taken BEQZ; HALT behind taken BEQZ
    tbl[5].code[0]  = 16'h6001;
    tbl[5].code[1]  = 16'h9006;
    tbl[5].code[2]  = 16'h6411;
    tbl[5].code[3]  = 16'h6000;
    tbl[5].code[4]  = 16'h900A;
    tbl[5].code[10] = 16'h6C33;
    wbe(5, 0, 0, 16'h01, 4);
    wbe(5, 1, 1, 16'h11, 6);
    wbe(5, 2, 0, 16'h00, 7);
    wbe(5, 3, 3, 16'h33, 11);
    tbl[5].nwb = 4; tbl[5].hc = 12; tbl[5].ck = 7; tbl[5].cpc = 10;

    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_pc", 32'(pc8), 0);
    check("rst_halted", 32'(h8), 0);
    check("rst_wb_valid", 32'(v8), 0);
    check("rst_wb_reg", 32'(r8), 0);
    check("rst_wb_data", 32'(d8), 0);

    for (int i = 0; i < 6; i++) run_tbl(i);

    // reset mid-run, just before ADD r1,r2 would commit
    load(tbl[0].code);
    push_tbl(0);
    hcnt = 0;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pc", 32'(pc8), 0);
    check("mid_rst_wb_valid", 32'(v8), 0);
    check("mid_rst_wb_data", 32'(d8), 0);
    check("mid_rst_halted", 32'(h8), 0);
    check("mid_rst_sb", sb.size(), 0);
    sb.delete();
    // registers cleared: ADD r1,r2 yields 0
    z = {16{16'hF000}};
    z[0] = 16'h1600;
    load(z);
    sb.push_back('{r: 2'd1, d: 16'h0, c: 4});
    go(5, 0, 8'h0);
    run_tbl(0);

    // 16-bit datapath: 0x80 doubled to 0x8000 then wraps to 0
    sel16 = 1'b1;
    z = {16{16'hF000}};
    z[0] = 16'h6480;
    for (int j = 1; j <= 9; j++) z[j] = 16'h1500;
    load(z);
    sb.push_back('{r: 2'd1, d: 16'h0080, c: 4});
    for (int j = 1; j <= 9; j++)
      sb.push_back('{r: 2'd1, d: 16'(32'h80 << j), c: 4 + j});
    go(14, 0, 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
